// File: rtl/task_dispatcher.sv
// Task dispatcher: walks task frames in program memory and streams each task's
// masks, r0 data and instructions to a masked core group with per-word valid/ack.
module task_dispatcher #(
  parameter int CORE_NUM    = 16,
  parameter int WORD_W      = 16,
  parameter int FRAME_WORDS = 16,
  parameter int ADDR_W      = 10,
  parameter int IF_W        = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_rd_data,
  input  logic [CORE_NUM-1:0] core_ready,
  input  logic [CORE_NUM-1:0] core_ack,
  output logic [WORD_W-1:0]   msg,
  output logic                msg_valid,
  output logic [1:0]          msg_kind,
  output logic                busy,
  output logic                done
);

  localparam int LOG_FW = $clog2(FRAME_WORDS);
  localparam int NB_W   = ADDR_W + IF_W + LOG_FW + 1;
  localparam logic [NB_W-1:0] ADDR_MAX = {{(NB_W-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};

  localparam logic [1:0] FENCE_ACQ = 2'b01;
  localparam logic [1:0] FENCE_REL = 2'b10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_HDR = 3'd1;
  localparam logic [2:0] S_RD_CM  = 3'd2;
  localparam logic [2:0] S_RD_RM  = 3'd3;
  localparam logic [2:0] S_GATE   = 3'd4;
  localparam logic [2:0] S_STREAM = 3'd5;
  localparam logic [2:0] S_ACQ    = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [IF_W-1:0]     if_num_q, if_num_d;
  logic [1:0]          fence_q, fence_d;
  logic [CORE_NUM-1:0] task_mask_q, task_mask_d;
  logic [WORD_W-1:0]   r0_mask_q, r0_mask_d;
  logic [ADDR_W-1:0]   off_q, off_d;
  logic [WORD_W-1:0]   msg_q, msg_d;
  logic [1:0]          kind_q, kind_d;
  logic                valid_q, valid_d;
  logic                rd_vld_q;

  logic [NB_W-1:0] task_len, next_base, last_off, nxt_word_addr;
  logic            accept, cores_clear, advance;

  assign task_len      = (NB_W'(if_num_q) + NB_W'(1)) << LOG_FW;
  assign next_base     = NB_W'(base_q) + task_len;
  assign last_off      = task_len - NB_W'(1);
  assign nxt_word_addr = NB_W'(base_q) + NB_W'(off_q) + NB_W'(1);
  assign accept        = valid_q && ((core_ack & task_mask_q) == task_mask_q);
  assign cores_clear   = (task_mask_q & ~core_ready) == '0;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    if_num_d    = if_num_q;
    fence_d     = fence_q;
    task_mask_d = task_mask_q;
    r0_mask_d   = r0_mask_q;
    off_d       = off_q;
    msg_d       = msg_q;
    kind_d      = kind_q;
    valid_d     = valid_q;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    advance     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RD_HDR;
          base_d  = '0;
        end
      end
      S_RD_HDR: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q;
        state_d   = S_RD_CM;
      end
      S_RD_CM: begin
        if (mem_rd_data == '1) begin
          state_d = S_DONE;
        end else begin
          if_num_d  = mem_rd_data[IF_W-1:0];
          fence_d   = mem_rd_data[7:6];
          mem_rd_en = 1'b1;
          mem_addr  = base_q + ADDR_W'(1);
          state_d   = S_RD_RM;
        end
      end
      S_RD_RM: begin
        task_mask_d = mem_rd_data[CORE_NUM-1:0];
        mem_rd_en   = 1'b1;
        mem_addr    = base_q + ADDR_W'(2);
        state_d     = S_GATE;
      end
      S_GATE: begin
        // r0 mask data is only on the bus during the first GATE cycle
        if (rd_vld_q) r0_mask_d = mem_rd_data;
        if (task_mask_q == '0) begin
          advance = 1'b1;
        end else if (cores_clear && (fence_q != FENCE_REL || (&core_ready))) begin
          state_d = S_STREAM;
          off_d   = ADDR_W'(1);
          msg_d   = WORD_W'(task_mask_q);
          kind_d  = 2'd0;
          valid_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (rd_vld_q) begin
          msg_d   = mem_rd_data;
          kind_d  = (off_q < ADDR_W'(FRAME_WORDS)) ? 2'd2 : 2'd3;
          valid_d = 1'b1;
        end else if (accept) begin
          valid_d = 1'b0;
          if (NB_W'(off_q) == last_off) begin
            if (fence_q == FENCE_ACQ) state_d = S_ACQ;
            else                      advance = 1'b1;
          end else if (off_q == ADDR_W'(1)) begin
            off_d   = off_q + ADDR_W'(1);
            msg_d   = r0_mask_q;
            kind_d  = 2'd1;
            valid_d = 1'b1;
          end else if (nxt_word_addr > ADDR_MAX) begin
            state_d = S_DONE;
          end else begin
            off_d     = off_q + ADDR_W'(1);
            mem_rd_en = 1'b1;
            mem_addr  = nxt_word_addr[ADDR_W-1:0];
          end
        end
      end
      S_ACQ: begin
        if (cores_clear) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Moving to the next task never wraps: running past the top of memory ends the program
    if (advance) begin
      if (next_base > ADDR_MAX) begin
        state_d = S_DONE;
      end else begin
        base_d  = next_base[ADDR_W-1:0];
        state_d = S_RD_HDR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      if_num_q    <= '0;
      fence_q     <= '0;
      task_mask_q <= '0;
      r0_mask_q   <= '0;
      off_q       <= '0;
      msg_q       <= '0;
      kind_q      <= '0;
      valid_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      if_num_q    <= if_num_d;
      fence_q     <= fence_d;
      task_mask_q <= task_mask_d;
      r0_mask_q   <= r0_mask_d;
      off_q       <= off_d;
      msg_q       <= msg_d;
      kind_q      <= kind_d;
      valid_q     <= valid_d;
      rd_vld_q    <= mem_rd_en;
    end
  end

  assign msg       = msg_q;
  assign msg_kind  = kind_q;
  assign msg_valid = valid_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_task_dispatcher.sv
// Bench for task_dispatcher: program memory model, directed scenarios and random
// programs, checked against expected message and read-address streams.
module tb_task_dispatcher;

  localparam int CN   = 16;
  localparam int WW   = 16;
  localparam int FW   = 16;
  localparam int AW   = 10;
  localparam int IW   = 6;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_rd_data;
  logic [CN-1:0] core_ready;
  logic [CN-1:0] core_ack;
  logic [WW-1:0] msg;
  logic          msg_valid;
  logic [1:0]    msg_kind;
  logic          busy;
  logic          done;

  task_dispatcher #(
    .CORE_NUM(CN), .WORD_W(WW), .FRAME_WORDS(FW), .ADDR_W(AW), .IF_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .core_ready(core_ready), .core_ack(core_ack),
    .msg(msg), .msg_valid(msg_valid), .msg_kind(msg_kind),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [0:AMAX];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  typedef struct packed {
    logic [15:0] w;
    logic [1:0]  k;
    logic [15:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   rd_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  bit   mon_en   = 1'b0;
  bit   rnd_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every presented word must match the head of the expected stream; acceptance pops it
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_rd_en) begin
        check_eq("rd_addr", 64'(mem_addr), (rd_q.size() > 0) ? 64'(rd_q[0]) : 64'h1_0000);
        if (rd_q.size() > 0) void'(rd_q.pop_front());
      end
      if (msg_valid) begin
        logic [15:0] m;
        check_eq("msg", 64'({msg_kind, msg}),
                 (exp_q.size() > 0) ? 64'({exp_q[0].k, exp_q[0].w}) : 64'h1_0000_0000);
        m = (exp_q.size() > 0) ? exp_q[0].m : 16'hFFFF;
        if (exp_q.size() > 0 && (core_ack & m) == m) begin
          void'(exp_q.pop_front());
          n_acc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      core_ready = ~CN'($urandom & $urandom & $urandom);
      core_ack   = ~CN'($urandom & $urandom & $urandom & $urandom);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i <= AMAX; i++) mem[i] = WW'($urandom);
  endtask

  function automatic void push_exp(input logic [15:0] w, input logic [1:0] k, input logic [15:0] m);
    exp_t e;
    e.w = w;
    e.k = k;
    e.m = m;
    exp_q.push_back(e);
  endfunction

  // Walk the program as the task layout describes it, listing reads and messages
  function automatic void build_exp();
    int b = 0;
    bit stop = 1'b0;
    exp_q.delete();
    rd_q.delete();
    while (!stop) begin
      logic [15:0] h;
      logic [15:0] m;
      int len;
      rd_q.push_back(b);
      h = mem[b];
      if (h == 16'hFFFF) break;
      rd_q.push_back(b + 1);
      rd_q.push_back(b + 2);
      m   = mem[b + 1];
      len = (int'(h[5:0]) + 1) * FW;
      if (m != 16'h0) begin
        push_exp(m, 2'd0, m);
        push_exp(mem[b + 2], 2'd1, m);
        for (int o = 3; o < len; o++) begin
          if (b + o > AMAX) begin
            stop = 1'b1;
            break;
          end
          rd_q.push_back(b + o);
          push_exp(mem[b + o], (o < FW) ? 2'd2 : 2'd3, m);
        end
      end
      if (!stop) begin
        if (b + len > AMAX) stop = 1'b1;
        else                b += len;
      end
    end
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int budget);
    for (int k = 0; k < budget && !done; k++) tick();
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_msgs_left"}, 64'(exp_q.size()), 64'd0);
    check_eq({tag, "_reads_left"}, 64'(rd_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 50 && !msg_valid; k++) tick();
    check_eq({tag, "_valid"}, 64'(msg_valid), 64'd1);
  endtask

  task automatic gate_test(input string tag, input logic [15:0] hdr, input logic [15:0] mask,
                           input logic [CN-1:0] blk);
    bit sawv = 1'b0;
    fill_mem();
    mem[0]  = hdr;
    mem[1]  = mask;
    mem[16] = 16'hFFFF;
    core_ready = blk;
    core_ack   = '1;
    build_exp();
    pulse_start();
    repeat (10) begin
      tick();
      sawv |= msg_valid;
    end
    check_eq({tag, "_stall"}, 64'(sawv), 64'd0);
    core_ready = '1;
    tick();
    check_eq({tag, "_go"}, 64'(msg_valid), 64'd1);
    finish_run(tag, 300);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fv, dk, b, nt;
    bit sawv, sawrd;

    reset = 1'b1;
    start = 1'b0;
    core_ready = '1;
    core_ack   = '1;
    repeat (3) tick();
    check_eq("reset_out", 64'({msg, msg_kind, msg_valid, mem_rd_en, mem_addr, busy, done}), 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // single task, mask 0x0003, one instruction frame
    fill_mem();
    mem[0]  = 16'h0001;
    mem[1]  = 16'h0003;
    mem[32] = 16'hFFFF;
    build_exp();
    n_acc = 0;
    pulse_start();
    check_eq("t1_first_read", 64'({busy, mem_rd_en, mem_addr}), 64'({1'b1, 1'b1, 10'd0}));
    fv = 0;
    dk = 0;
    for (int k = 2; k <= 200 && dk == 0; k++) begin
      tick();
      if (msg_valid && fv == 0) fv = k;
      if (done) dk = k;
    end
    check_eq("t1_first_valid_cycle", 64'(fv), 64'd5);
    check_eq("t1_done_cycle", 64'(dk), 64'd67);
    check_eq("t1_words", 64'(n_acc), 64'd31);
    repeat (3) tick();
    check_eq("t1_done_hold", 64'({done, busy}), 64'({1'b1, 1'b0}));
    finish_run("t1", 10);

    gate_test("collision", 16'h0000, 16'h0001, 16'hFFFE);
    gate_test("rel", 16'h0080, 16'h0010, 16'h7FFF);

    // acquire fence holds the next header read until the masked core is idle again
    fill_mem();
    mem[0]  = 16'h0040;
    mem[1]  = 16'h0004;
    mem[16] = 16'hFFFF;
    core_ready = '1;
    core_ack   = '1;
    build_exp();
    pulse_start();
    wait_valid("acq");
    core_ready = 16'hFFFB;
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) tick();
    check_eq("acq_words", 64'(exp_q.size()), 64'd0);
    sawrd = mem_rd_en;
    repeat (10) begin
      tick();
      sawrd |= mem_rd_en;
    end
    check_eq("acq_hold", 64'(sawrd), 64'd0);
    core_ready = '1;
    tick();
    check_eq("acq_release", 64'({mem_rd_en, mem_addr}), 64'({1'b1, 10'd16}));
    finish_run("acq", 50);

    // partial ack, plus an ack on a core outside the mask
    fill_mem();
    mem[0]  = 16'h0000;
    mem[1]  = 16'h0003;
    mem[16] = 16'hFFFF;
    core_ack = 16'h0021;
    build_exp();
    n_acc = 0;
    pulse_start();
    wait_valid("pack");
    repeat (6) tick();
    check_eq("pack_hold", 64'({msg_valid, mem_rd_en, msg_kind, msg}), 64'({1'b1, 1'b0, 2'd0, 16'h0003}));
    check_eq("pack_noacc", 64'(n_acc), 64'd0);
    core_ack = 16'h0003;
    finish_run("pack", 300);
    core_ack = '1;

    // empty-mask task is skipped in four cycles
    fill_mem();
    mem[0]  = 16'h0002;
    mem[1]  = 16'h0000;
    mem[48] = 16'h0001;
    mem[49] = 16'h0101;
    mem[80] = 16'hFFFF;
    build_exp();
    pulse_start();
    sawv = 1'b0;
    repeat (3) begin
      tick();
      sawv |= msg_valid;
    end
    tick();
    check_eq("skip_no_valid", 64'(sawv), 64'd0);
    check_eq("skip_next_hdr", 64'({mem_rd_en, mem_addr}), 64'({1'b1, 10'd48}));
    finish_run("skip", 400);

    // reset in the middle of streaming
    fill_mem();
    mem[0]  = 16'h0001;
    mem[1]  = 16'h0005;
    mem[32] = 16'hFFFF;
    build_exp();
    pulse_start();
    wait_valid("rst");
    repeat (7) tick();
    mon_en = 1'b0;
    reset  = 1'b1;
    tick();
    check_eq("rst_mid", 64'({msg, msg_kind, msg_valid, mem_rd_en, mem_addr, busy, done}), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    rd_q.delete();
    mon_en = 1'b1;
    tick();

    // instruction fetch would pass the top of memory; a start while busy is ignored
    fill_mem();
    mem[0]    = 16'h003E;
    mem[1]    = 16'h8001;
    mem[1008] = 16'h0001;
    mem[1009] = 16'h0003;
    build_exp();
    pulse_start();
    repeat (100) tick();
    pulse_start();
    finish_run("limit", 5000);

    rnd_mode = 1'b1;
    for (int p = 0; p < 6; p++) begin
      fill_mem();
      b  = 0;
      nt = int'($urandom_range(2, 4));
      for (int t = 0; t < nt; t++) begin
        logic [5:0] ifn;
        logic [1:0] fence;
        ifn   = 6'($urandom_range(0, 2));
        fence = 2'($urandom);
        mem[b]     = {8'($urandom), fence, ifn};
        mem[b + 1] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom);
        b += (int'(ifn) + 1) * FW;
      end
      mem[b] = 16'hFFFF;
      build_exp();
      pulse_start();
      finish_run("random", 5000);
    end
    rnd_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
